// File: rtl/ad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : ad_pkg                                                         |
// | Purpose   : Shared types and defaults for the AD frame store               |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package ad_pkg;

  localparam int AD_DSIZE  = 8;
  localparam int AD_WORD_W = 2 * AD_DSIZE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_READOUT = 2'd3
  } ad_state_e;

endpackage
`default_nettype wire

// File: rtl/ad_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : ad_sdp_ram                                                     |
// | Purpose   : Simple dual-port RAM, one write port, one registered read port |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module ad_sdp_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port: data appears the cycle after re
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/ad_frame_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : ad_frame_store                                                 |
// | Purpose   : Captures one frame of paired AD samples into RAM and streams   |
// |             it out over a valid/ready port on request.                     |
// | Options   : AD_PEAK_DETECT_EN adds o_peak / o_peak_idx peak tracking.      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module ad_frame_store
  import ad_pkg::*;
#(
  parameter int DSIZE = AD_DSIZE,
  parameter int AW    = 10
) (
  input  logic               i_ad_clk,
  input  logic               i_rst_n,
  input  logic [2*DSIZE-1:0] i_dual_data,
  input  logic               i_data_on,
  input  logic               i_working,
  input  logic               i_rd_start,
  input  logic               i_rd_ready,
  output logic [2*DSIZE-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_rd_last,
  output logic               o_frame_ready,
  output logic [AW:0]        o_frame_words,
  output logic               o_overflow,
  output logic               o_busy
`ifdef AD_PEAK_DETECT_EN
  ,
  output logic [DSIZE-1:0]   o_peak,
  output logic [AW+1:0]      o_peak_idx
`endif
);

  localparam int          WW      = 2 * DSIZE;
  localparam int          DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];

  ad_state_e       state, state_nxt;
  logic            working_d;
  logic            w_rise, w_fall;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            wr_en, drop;
  logic [AW:0]     frame_words_final, last_idx;
  logic            enter_capture, enter_readout, empty_start;
  logic [WW-1:0]   ram_rdata;
  logic            rd_issue, ram_valid, ram_last;
  logic            out_valid, out_last, skid_valid, skid_last;
  logic [WW-1:0]   out_data, skid_data;
  logic            pop, done;
  logic [1:0]      occ_after;

  assign w_rise = i_working & ~working_d;
  assign w_fall = ~i_working & working_d;

  // wr_ptr == DEPTH (MSB set) is the full condition; the pointer never wraps
  assign wr_en = (state == ST_CAPTURE) && i_data_on && !wr_ptr[AW];
  assign drop  = (state == ST_CAPTURE) && i_data_on &&  wr_ptr[AW];
  assign frame_words_final = wr_ptr + {{AW{1'b0}}, wr_en};

  assign enter_capture = (state_nxt == ST_CAPTURE) && (state != ST_CAPTURE);
  assign enter_readout = (state_nxt == ST_READOUT) && (state != ST_READOUT);
  assign empty_start   = (state == ST_READY) && (state_nxt == ST_IDLE);

  assign pop  = out_valid & i_rd_ready;
  assign done = pop & out_last;

  // Fetch credit: words buffered plus in flight must stay within the 2-entry skid
  assign occ_after = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, ram_valid} - {1'b0, pop};
  assign last_idx  = o_frame_words - {{AW{1'b0}}, 1'b1};
  assign rd_issue  = (state == ST_READOUT) && (rd_ptr < o_frame_words) && (occ_after < 2'd2);

  assign o_rd_data  = out_data;
  assign o_rd_valid = out_valid;
  assign o_rd_last  = out_valid & out_last;

  // State register and working edge-detect history
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      working_d <= 1'b0;
    end else begin
      state     <= state_nxt;
      working_d <= i_working;
    end
  end

  // Next-state decode and busy flag
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (w_rise) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        o_busy = 1'b1;
        if (w_fall) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (w_rise)          state_nxt = ST_CAPTURE;
        else if (i_rd_start) state_nxt = (o_frame_words != '0) ? ST_READOUT : ST_IDLE;
      end
      ST_READOUT: begin
        o_busy = 1'b1;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write pointer and frame status; status holds until the next capture starts
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      o_overflow    <= 1'b0;
      o_frame_ready <= 1'b0;
      o_frame_words <= '0;
    end else if (enter_capture) begin
      wr_ptr        <= '0;
      o_overflow    <= 1'b0;
      o_frame_ready <= 1'b0;
      o_frame_words <= '0;
    end else if (state == ST_CAPTURE) begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (drop)  o_overflow <= 1'b1;
      if (w_fall) begin
        o_frame_words <= frame_words_final;
        o_frame_ready <= 1'b1;
      end
    end else if (empty_start || done) begin
      o_frame_ready <= 1'b0;
    end
  end

  // Read pointer plus tracking of the word currently inside the RAM read stage
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      ram_last  <= 1'b0;
    end else begin
      if (enter_readout)  rd_ptr <= '0;
      else if (rd_issue)  rd_ptr <= rd_ptr + 1'b1;
      ram_valid <= rd_issue;
      ram_last  <= rd_issue && (rd_ptr == last_idx);
    end
  end

  // Output register with one skid entry; head is frozen while stalled
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= ram_valid;
        skid_data  <= ram_rdata;
        skid_last  <= ram_last;
      end else begin
        out_valid  <= ram_valid;
        out_data   <= ram_rdata;
        out_last   <= ram_last;
      end
    end else if (ram_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= ram_rdata;
      skid_last  <= ram_last;
    end
  end

  ad_sdp_ram #(
    .DW (WW),
    .AW (AW)
  ) u_ram (
    .clk   (i_ad_clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (i_dual_data),
    .re    (rd_issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef AD_PEAK_DETECT_EN
  logic [DSIZE-1:0] pk_mid;
  logic [AW+1:0]    idx_mid;

  // Upper (older) sample is compared first; strict greater keeps first occurrence
  always_comb begin
    pk_mid  = o_peak;
    idx_mid = o_peak_idx;
    if (i_dual_data[WW-1:DSIZE] > pk_mid) begin
      pk_mid  = i_dual_data[WW-1:DSIZE];
      idx_mid = {wr_ptr, 1'b0};
    end
    if (i_dual_data[DSIZE-1:0] > pk_mid) begin
      pk_mid  = i_dual_data[DSIZE-1:0];
      idx_mid = {wr_ptr, 1'b1};
    end
  end

  // Peak register: cleared at capture start, updated only by stored words
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_peak     <= '0;
      o_peak_idx <= '0;
    end else if (enter_capture) begin
      o_peak     <= '0;
      o_peak_idx <= '0;
    end else if (wr_en) begin
      o_peak     <= pk_mid;
      o_peak_idx <= idx_mid;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_ad_frame_store                                              |
// | Purpose   : Randomised self-checking bench for ad_frame_store (AW=4)       |
// | Options   : AD_PEAK_DETECT_EN enables the peak tracker checks.             |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ad_frame_store;

  localparam int DSIZE = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*DSIZE-1:0] dual_data;
  logic              data_on, working, rd_start, rd_ready;
  logic [2*DSIZE-1:0] rd_data;
  logic              rd_valid, rd_last, frame_ready, overflow, busy;
  logic [AW:0]       frame_words;
`ifdef AD_PEAK_DETECT_EN
  logic [DSIZE-1:0]  peak;
  logic [AW+1:0]     peak_idx;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: the words the frame should hold, and how many were offered
  logic [15:0] model_q[$];
  int          n_offered;

  always #5 clk = ~clk;

  ad_frame_store #(.DSIZE(DSIZE), .AW(AW)) dut (
    .i_ad_clk      (clk),
    .i_rst_n       (rst_n),
    .i_dual_data   (dual_data),
    .i_data_on     (data_on),
    .i_working     (working),
    .i_rd_start    (rd_start),
    .i_rd_ready    (rd_ready),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .o_rd_last     (rd_last),
    .o_frame_ready (frame_ready),
    .o_frame_words (frame_words),
    .o_overflow    (overflow),
    .o_busy        (busy)
`ifdef AD_PEAK_DETECT_EN
    ,
    .o_peak        (peak),
    .o_peak_idx    (peak_idx)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] gen_word(input int wmode, input int k);
    logic [7:0] hi, lo;
    logic [15:0] tbl [3];
    tbl[0] = 16'h1040; tbl[1] = 16'h40F0; tbl[2] = 16'hF010;
    hi = 8'(2 * k + 1);
    lo = 8'(2 * k + 2);
    if (wmode == 1) return {hi, lo};
    if (wmode == 2 && k < 3) return tbl[k];
    return 16'($urandom);
  endfunction

  // Drive one acquisition window. Cycle 0 is the rising edge (still idle),
  // cycles 1..ncyc-1 are inside the window, the last cycle has working low.
  // on_mode: 0 alternating, 1 always, 2 random, 3 never.
  task automatic do_capture(input int ncyc, input int on_mode, input int wmode,
                            input bit fall_word, input bit poke_start);
    bit          on;
    logic [15:0] w;
    model_q.delete();
    n_offered = 0;
    for (int c = 0; c <= ncyc; c++) begin
      if (c == ncyc) begin
        working = 1'b0;
        on      = fall_word;
      end else begin
        working = 1'b1;
        case (on_mode)
          0:       on = (c % 2) == 1;
          1:       on = (c != 0);
          2:       on = (c != 0) && ($urandom_range(0, 1) == 1);
          default: on = 1'b0;
        endcase
      end
      w         = gen_word(wmode, n_offered);
      dual_data = w;
      data_on   = on;
      rd_start  = poke_start && (c == 3);
      @(negedge clk);
      if (on) begin
        n_offered++;
        if (model_q.size() < DEPTH) model_q.push_back(w);
      end
    end
    data_on  = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check_val({tag, "_ready"}, frame_ready, 1);
    check_val({tag, "_words"}, frame_words, model_q.size());
    check_val({tag, "_ovf"}, overflow, (n_offered > DEPTH));
    check_val({tag, "_busy"}, busy, 0);
`ifdef AD_PEAK_DETECT_EN
    begin
      logic [7:0] pk;
      int         pi;
      pk = 0; pi = 0;
      foreach (model_q[i]) begin
        if (model_q[i][15:8] > pk) begin pk = model_q[i][15:8]; pi = 2 * i; end
        if (model_q[i][7:0]  > pk) begin pk = model_q[i][7:0];  pi = 2 * i + 1; end
      end
      check_val({tag, "_peak"}, peak, pk);
      check_val({tag, "_peak_idx"}, peak_idx, pi);
    end
`endif
  endtask

  // Read the frame back. rmode: 0 ready held, 1 toggling 1010.., 2 random.
  // disturb raises working and pulses rd_start mid-stream.
  task automatic do_readout(input string tag, input int rmode, input bit disturb);
    int idx = 0, cyc = 0, first = -1, bubbles = 0, late = 0;
    int n = model_q.size();
    bit stalled = 0, r;
    rd_start = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    cyc = 1;
    while (idx < n && cyc < 400) begin
      if (stalled) check_val({tag, "_stall_hold"}, rd_valid, 1);
      if (rd_valid) begin
        if (first < 0) first = cyc;
        check_val({tag, "_data"}, rd_data, model_q[idx]);
        check_val({tag, "_last"}, rd_last, (idx == n - 1));
      end else if (first >= 0 && rmode == 0) begin
        bubbles++;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 1;
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      if (disturb) begin
        if (cyc == 4) begin working = 1'b1; rd_start = 1'b1; end
        if (cyc == 5) rd_start = 1'b0;
        if (cyc == 6) working = 1'b0;
      end
      if (rd_valid && r) idx++;
      stalled  = rd_valid && !r;
      rd_ready = r;
      @(negedge clk);
      cyc++;
    end
    rd_start = 1'b0;
    working  = 1'b0;
    if (idx < n) check_val({tag, "_timeout"}, idx, n);
    check_val({tag, "_latency"}, first, 3);
    if (rmode == 0) check_val({tag, "_bubbles"}, bubbles, 0);
    check_val({tag, "_end_busy"}, busy, 0);
    check_val({tag, "_end_fready"}, frame_ready, 0);
    for (int k = 0; k < 4; k++) begin
      if (rd_valid) late++;
      @(negedge clk);
    end
    check_val({tag, "_no_extra"}, late, 0);
  endtask

  task automatic do_empty_read(input string tag);
    int seen = 0;
    rd_start = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rd_valid) seen++;
      @(negedge clk);
    end
    check_val({tag, "_valid"}, seen, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, rd_valid, 0);
    check_val({tag, "_last"}, rd_last, 0);
    check_val({tag, "_data"}, rd_data, 0);
    check_val({tag, "_fready"}, frame_ready, 0);
    check_val({tag, "_words"}, frame_words, 0);
    check_val({tag, "_ovf"}, overflow, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; dual_data = '0; data_on = 1'b0; working = 1'b0;
    rd_start = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Six words on alternating cycles, sequential pattern
    do_capture(12, 0, 1, 1'b0, 1'b0);
    check_val("t1_count", frame_words, 6);
    check_frame("t1");
    do_readout("t1", 0, 1'b0);

    // Overflow: 20 offered, 16 kept
    do_capture(20, 1, 0, 1'b1, 1'b0);
    check_val("t2_ovf", overflow, 1);
    check_frame("t2");
    do_readout("t2", 1, 1'b0);

    // rd_start during capture ignored; working rise during readout ignored
    do_capture(14, 2, 0, 1'b1, 1'b1);
    check_frame("t4");
    do_readout("t4", 1, 1'b1);

    // Empty frame then rd_start returns to idle with no data
    do_capture(5, 3, 0, 1'b0, 1'b0);
    check_frame("t4e");
    do_empty_read("t4e");

    // Reset in the middle of a capture
    working = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dual_data = 16'($urandom); data_on = 1'b1;
      @(negedge clk);
    end
    data_on = 1'b0;
    check_val("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    working = 1'b0;
    #1;
    check_reset_outputs("t5");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_capture(10, 1, 0, 1'b1, 1'b0);
    check_frame("t5n");
    do_readout("t5n", 0, 1'b0);

`ifdef AD_PEAK_DETECT_EN
    do_capture(4, 1, 2, 1'b0, 1'b0);
    check_val("t6_peak", peak, 8'hF0);
    check_val("t6_peak_idx", peak_idx, 3);
    check_frame("t6");
    do_readout("t6", 0, 1'b0);
`endif

    // Randomised frames and backpressure
    for (int t = 0; t < 6; t++) begin
      do_capture($urandom_range(2, 30), 2, 0, 1'($urandom_range(0, 1)), 1'b0);
      check_frame("rnd");
      if (model_q.size() == 0) do_empty_read("rnd_e");
      else do_readout("rnd", (t % 2 == 0) ? 2 : 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
